// File: rtl/rng_range_sampler_if.sv
// Request / RNG-source / result channels of rng_range_sampler.
// master = client + RNG side, slave = sampler.
interface rng_range_sampler_if #(
  parameter int WIDTH     = 32,
  parameter int MAX_TRIES = 16
);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic             req_valid;
  logic [WIDTH-1:0] req_bound;
  logic             req_ready;
  logic             src_valid;
  logic [WIDTH-1:0] src_data;
  logic             src_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TW-1:0]    out_tries;
  logic             out_err;

  modport master (
    output req_valid, req_bound, src_valid, src_data, out_ready,
    input  req_ready, src_ready, out_valid, out_data, out_tries, out_err
  );

  modport slave (
    input  req_valid, req_bound, src_valid, src_data, out_ready,
    output req_ready, src_ready, out_valid, out_data, out_tries, out_err
  );
endinterface

// File: rtl/rng_range_sampler.sv
// Draws unbiased samples in [0, bound) from an RNG word stream by masked rejection.
// Latency: 2 cycles minimum (request -> first draw -> result), +1 per rejected word.
// Backpressure: src stalls freeze DRAW; result is held in HOLD until out_ready.
module rng_range_sampler #(
  parameter int WIDTH     = 32,
  parameter int MAX_TRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  rng_range_sampler_if.slave io
);
  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] bound_q, bound_n;
  logic [WIDTH-1:0] mask_q, mask_n;
  logic [TW-1:0]    tries_q, tries_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [TW-1:0]    otries_q, otries_n;
  logic             err_q, err_n;

  logic [WIDTH-1:0] req_mask;
  logic [WIDTH-1:0] cand;
  logic [TW-1:0]    tries_inc;

  // Smear bound-1 downward so the mask covers every value up to bound-1.
  always_comb begin
    req_mask = io.req_bound - {{(WIDTH-1){1'b0}}, 1'b1};
    for (int s = 1; s < WIDTH; s = s * 2) begin
      req_mask = req_mask | (req_mask >> s);
    end
  end

  assign cand      = io.src_data & mask_q;
  assign tries_inc = tries_q + {{(TW-1){1'b0}}, 1'b1};

  always_comb begin
    state_n  = state;
    bound_n  = bound_q;
    mask_n   = mask_q;
    tries_n  = tries_q;
    data_n   = data_q;
    otries_n = otries_q;
    err_n    = err_q;
    unique case (state)
      IDLE: begin
        if (io.req_valid) begin
          bound_n = io.req_bound;
          mask_n  = req_mask;
          tries_n = '0;
          if (io.req_bound == '0) begin
            data_n   = '0;
            otries_n = '0;
            err_n    = 1'b1;
            state_n  = HOLD;
          end else begin
            state_n = DRAW;
          end
        end
      end
      DRAW: begin
        if (io.src_valid) begin
          tries_n = tries_inc;
          if (cand < bound_q) begin
            data_n   = cand;
            otries_n = tries_inc;
            err_n    = 1'b0;
            state_n  = HOLD;
          end else if (tries_inc == TW'(MAX_TRIES)) begin
            // cand <= mask < 2*bound, so one subtraction lands in range.
            data_n   = cand - bound_q;
            otries_n = tries_inc;
            err_n    = 1'b1;
            state_n  = HOLD;
          end
        end
      end
      HOLD: begin
        if (io.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bound_q  <= '0;
      mask_q   <= '0;
      tries_q  <= '0;
      data_q   <= '0;
      otries_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      bound_q  <= bound_n;
      mask_q   <= mask_n;
      tries_q  <= tries_n;
      data_q   <= data_n;
      otries_q <= otries_n;
      err_q    <= err_n;
    end
  end

  assign io.req_ready = (state == IDLE);
  assign io.src_ready = (state == DRAW);
  assign io.out_valid = (state == HOLD);
  assign io.out_data  = data_q;
  assign io.out_tries = otries_q;
  assign io.out_err   = err_q;
endmodule

// File: tb/tb_rng_range_sampler.sv
// Directed plus randomized checks of rng_range_sampler against a loop-based reference model.
module tb_rng_range_sampler;
  localparam int W  = 32;
  localparam int MT = 4;
  localparam int TW = $clog2(MT + 1);

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   stall_pct;
  logic [W-1:0] dir_q[$];

  rng_range_sampler_if #(.WIDTH(W), .MAX_TRIES(MT)) bus ();

  rng_range_sampler #(.WIDTH(W), .MAX_TRIES(MT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: smallest all-ones mask covering b-1, then try words in order.
  function automatic void model(input longint unsigned b, input logic [W-1:0] w[$],
                                output longint unsigned d, output int t,
                                output logic e, output int used);
    longint unsigned m;
    longint unsigned c;
    d = 0; t = 0; e = 1'b1; used = 0;
    if (b == 0) return;
    m = 0;
    while (m < b - 1) m = m * 2 + 1;
    for (int i = 0; i < MT; i++) begin
      if (i >= w.size()) begin
        used = -1;
        return;
      end
      c = longint'(w[i]) & m;
      if (c < b) begin
        d = c; t = i + 1; e = 1'b0; used = i + 1;
        return;
      end
      if (i + 1 == MT) begin
        d = c - b; t = MT; e = 1'b1; used = MT;
        return;
      end
    end
  endfunction

  task automatic run_req(input logic [W-1:0] b, input int hold);
    logic [W-1:0]    used_q[$];
    int              cyc;
    logic            hs;
    logic            hs_prev;
    longint unsigned ed;
    int              et;
    logic            ee;
    int              eu;
    logic [W-1:0]    sd;
    logic [TW-1:0]   st;
    logic            se;

    cyc = 0;
    while (!bus.req_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_bound = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_bound = $urandom;
    if (b == 0) begin
      chk("b0_out_valid_next", 64'(bus.out_valid), 64'd1);
      chk("b0_no_src_ready", 64'(bus.src_ready), 64'd0);
    end else begin
      chk("src_ready_next", 64'(bus.src_ready), 64'd1);
    end

    cyc = 0;
    hs_prev = 1'b0;
    while (!bus.out_valid && cyc < 300) begin
      bus.src_valid = ($urandom_range(0, 99) >= stall_pct);
      bus.src_data  = (dir_q.size() > 0) ? dir_q[0] : $urandom;
      hs = bus.src_valid && bus.src_ready;
      if (hs) begin
        used_q.push_back(bus.src_data);
        if (dir_q.size() > 0) void'(dir_q.pop_front());
      end
      @(posedge clk); #1;
      bus.src_valid = 1'b0;
      hs_prev = hs;
      cyc++;
    end
    chk("result_timeout", 64'(bus.out_valid), 64'd1);
    if (b != 0) chk("out_after_last_word", 64'(hs_prev), 64'd1);

    model(longint'(b), used_q, ed, et, ee, eu);
    chk("words_consumed", 64'(used_q.size()), 64'(eu));
    chk("out_data", 64'(bus.out_data), ed);
    chk("out_tries", 64'(bus.out_tries), 64'(et));
    chk("out_err", 64'(bus.out_err), 64'(ee));
    if (b != 0) chk("out_in_range", 64'(bus.out_data < b), 64'd1);

    sd = bus.out_data; st = bus.out_tries; se = bus.out_err;
    for (int k = 0; k < hold; k++) begin
      bus.out_ready = 1'b0;
      bus.src_valid = 1'b1;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", 64'(bus.out_data), 64'(sd));
      chk("hold_tries", 64'(bus.out_tries), 64'(st));
      chk("hold_err", 64'(bus.out_err), 64'(se));
      chk("hold_src_ready", 64'(bus.src_ready), 64'd0);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.src_valid = 1'b0;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_after_out", 64'(bus.req_ready), 64'd1);
    chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
    dir_q.delete();
  endtask

  initial begin
    logic [W-1:0] rb;
    int           kk;
    total = 0; bad = 0; stall_pct = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_bound = '0;
    bus.src_valid = 1'b0; bus.src_data  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_src_ready", 64'(bus.src_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_tries", 64'(bus.out_tries), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reject 12, accept 7.
    dir_q = '{32'h0000000C, 32'h00000017};
    run_req(32'd10, 0);
    chk("t1_data", 64'(bus.out_data), 64'd7);

    dir_q = '{32'hFFFFFFFF};
    run_req(32'd1, 0);
    run_req(32'd0, 0);

    // Four rejects exhaust MAX_TRIES: fallback 15-9.
    dir_q = '{32'h0F, 32'h0F, 32'h0F, 32'h0F};
    run_req(32'd9, 0);
    chk("t3_data", 64'(bus.out_data), 64'd6);

    dir_q = '{32'h5};
    run_req(32'd10, 5);

    // Reset in the middle of DRAW after two rejects.
    bus.req_valid = 1'b1; bus.req_bound = 32'd10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.src_valid = 1'b1; bus.src_data = 32'h0F;
    @(posedge clk); #1;
    bus.src_data = 32'h0C;
    @(posedge clk); #1;
    bus.src_valid = 1'b0;
    chk("t6_still_draw", 64'(bus.src_ready), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_req_ready", 64'(bus.req_ready), 64'd1);
    chk("t6_src_ready", 64'(bus.src_ready), 64'd0);
    chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_out_data", 64'(bus.out_data), 64'd0);
    chk("t6_out_tries", 64'(bus.out_tries), 64'd0);
    chk("t6_out_err", 64'(bus.out_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dir_q = '{32'h3};
    run_req(32'd10, 0);

    stall_pct = 50;
    run_req(32'h80000001, 0);

    for (int n = 0; n < 40; n++) begin
      stall_pct = $urandom_range(0, 60);
      kk = $urandom_range(0, 31);
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'd1 << kk;
        3:       rb = (32'd1 << kk) + 32'd1;
        default: rb = $urandom;
      endcase
      run_req(rb, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
